// File: rtl/tlb_lru_update.sv
// rtl/tlb_lru_update.sv - TLB LRU age-counter writer (max+1 update, rank renorm, flush sweep); optional TLB_LRU_STATS_EN adds renorm_cnt
module tlb_lru_update #(
  parameter int NUM_WAYS = 4,
  parameter int LRU_BITS = 4,
  parameter int NUM_SETS = 16,
  parameter int SET_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         acc_valid,
  output logic                         acc_ready,
  input  logic [SET_BITS-1:0]          acc_set,
  input  logic [1:0]                   acc_way,
  input  logic                         flush,
  output logic                         flush_done,
  input  logic [SET_BITS-1:0]          rd_set,
  output logic [NUM_WAYS*LRU_BITS-1:0] rd_counts,
`ifdef TLB_LRU_STATS_EN
  output logic [15:0]                  renorm_cnt,
`endif
  output logic                         busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RENORM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  localparam logic [LRU_BITS-1:0] SAT      = {LRU_BITS{1'b1}};
  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);

  state_t state, next_state;

  logic [LRU_BITS-1:0] cnt [NUM_SETS][NUM_WAYS];
  logic [LRU_BITS-1:0] max_cnt;
  logic [LRU_BITS-1:0] rank [NUM_WAYS];
  logic [SET_BITS-1:0] lat_set;
  logic [1:0]          lat_way;
  logic [SET_BITS-1:0] sweep;
  logic                flush_pending;
  logic                go_flush;
  logic                accept;

  // Largest age in the accessed set; the touched way becomes max+1.
  always_comb begin
    max_cnt = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (cnt[acc_set][w] > max_cnt) max_cnt = cnt[acc_set][w];
    end
  end

  // Ties are broken by way index so the ranks form a permutation of 0..NUM_WAYS-1.
  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) begin
      rank[i] = '0;
      for (int j = 0; j < NUM_WAYS; j++) begin
        if ((cnt[lat_set][j] < cnt[lat_set][i]) ||
            ((cnt[lat_set][j] == cnt[lat_set][i]) && (j < i))) begin
          rank[i] = rank[i] + LRU_BITS'(1);
        end
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_counts[w*LRU_BITS +: LRU_BITS] = cnt[rd_set][w];
    end
  end

  always_comb begin
    next_state = state;
    acc_ready  = 1'b0;
    busy       = 1'b0;
    go_flush   = flush || flush_pending;
    case (state)
      S_IDLE: begin
        acc_ready = !go_flush;
        if (go_flush) begin
          next_state = S_FLUSH;
        end else if (acc_valid && (max_cnt == SAT)) begin
          next_state = S_RENORM;
        end
      end
      S_RENORM: begin
        busy       = 1'b1;
        next_state = S_IDLE;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (sweep == LAST_SET) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign accept = acc_valid && acc_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          cnt[s][w] <= '0;
        end
      end
      lat_set       <= '0;
      lat_way       <= '0;
      sweep         <= '0;
      flush_pending <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go_flush) begin
            flush_pending <= 1'b0;
            sweep         <= '0;
          end else if (accept) begin
            if (max_cnt != SAT) begin
              cnt[acc_set][acc_way] <= max_cnt + LRU_BITS'(1);
            end else begin
              lat_set <= acc_set;
              lat_way <= acc_way;
            end
          end
        end
        S_RENORM: begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (2'(w) == lat_way) begin
              cnt[lat_set][w] <= LRU_BITS'(NUM_WAYS);
            end else begin
              cnt[lat_set][w] <= rank[w];
            end
          end
        end
        S_FLUSH: begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            cnt[sweep][w] <= '0;
          end
          sweep <= sweep + SET_BITS'(1);
          if (sweep == LAST_SET) flush_done <= 1'b1;
        end
        default: ;
      endcase
      // A flush that arrives while busy is remembered until the next idle cycle.
      if (flush && (state != S_IDLE)) flush_pending <= 1'b1;
    end
  end

`ifdef TLB_LRU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      renorm_cnt <= '0;
    end else if ((state == S_RENORM) && (renorm_cnt != 16'hFFFF)) begin
      renorm_cnt <= renorm_cnt + 16'd1;
    end
  end
`endif

endmodule
